// File: rtl/mp_ar_arbiter.sv
// Round-robin arbiter sharing one AXI AR channel among ENGINE_NUM engines, tagging ARID with the
// engine index, capping in-flight bursts per engine and routing R handshakes back by RID.
// Optional per-engine grant counters are built when MP_AR_ARB_GRANT_CNT_EN is defined.
module mp_ar_arbiter #(
  parameter int ENGINE_NUM      = 8,
  parameter int ENG_BITS        = 3,
  parameter int ID_WIDTH        = 5,
  parameter int ADDR_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ENGINE_NUM-1:0]          eng_arvalid,
  input  logic [ENGINE_NUM*ADDR_WIDTH-1:0] eng_araddr,
  input  logic [ENGINE_NUM*8-1:0]        eng_arlen,
  output logic [ENGINE_NUM-1:0]          eng_arready,
  output logic [ID_WIDTH-1:0]            m_arid,
  output logic [ADDR_WIDTH-1:0]          m_araddr,
  output logic [7:0]                     m_arlen,
  output logic                           m_arvalid,
  input  logic                           m_arready,
  input  logic [ID_WIDTH-1:0]            m_rid,
  input  logic                           m_rlast,
  input  logic                           m_rvalid,
  output logic                           m_rready,
  output logic [ENGINE_NUM-1:0]          eng_rvalid,
  input  logic [ENGINE_NUM-1:0]          eng_rready,
  output logic [ENGINE_NUM*4-1:0]        outstanding,
  output logic                           rid_err
`ifdef MP_AR_ARB_GRANT_CNT_EN
  ,
  output logic [ENGINE_NUM*32-1:0]       grant_cnt
`endif
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                state_q;
  logic                  m_arvalid_q;
  logic [ID_WIDTH-1:0]   m_arid_q;
  logic [ADDR_WIDTH-1:0] m_araddr_q;
  logic [7:0]            m_arlen_q;
  logic [ENG_BITS-1:0]   ptr_q;
  logic                  rid_err_q;

  logic [ENGINE_NUM-1:0] eligible;
  logic [ENGINE_NUM-1:0] underflow;
  logic [ADDR_WIDTH-1:0] addr_arr [ENGINE_NUM];
  logic [7:0]            len_arr  [ENGINE_NUM];
  logic                  slot_free;
  logic                  found;
  logic                  grant;
  logic [ENG_BITS-1:0]   winner;
  logic [ENG_BITS-1:0]   rid_idx;
  logic                  rid_hi_ok;
  logic                  rid_ok;
  logic                  r_done;

  // The slot can take a new burst when empty or when it drains this very cycle.
  assign slot_free = !reset && ((state_q == IDLE) || m_arready);
  assign grant     = found && slot_free;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int off = 0; off < ENGINE_NUM; off++) begin
      if (!found && eligible[ptr_q + ENG_BITS'(off)]) begin
        found  = 1'b1;
        winner = ptr_q + ENG_BITS'(off);
      end
    end
  end

  always_comb begin
    eng_arready = '0;
    if (grant) eng_arready[winner] = 1'b1;
  end

  assign rid_idx = m_rid[ENG_BITS-1:0];
  generate
    if (ID_WIDTH > ENG_BITS) begin : g_rid_hi
      assign rid_hi_ok = (m_rid[ID_WIDTH-1:ENG_BITS] == '0);
    end else begin : g_rid_nohi
      assign rid_hi_ok = 1'b1;
    end
  endgenerate
  assign rid_ok = rid_hi_ok && ({1'b0, rid_idx} < (ENG_BITS+1)'(ENGINE_NUM));

  // Bad RIDs are drained so the host never stalls on a beat nobody owns.
  always_comb begin
    eng_rvalid = '0;
    m_rready   = 1'b1;
    if (rid_ok) begin
      eng_rvalid[rid_idx] = m_rvalid;
      m_rready            = eng_rready[rid_idx];
    end
  end

  assign r_done = m_rvalid && m_rready && m_rlast && rid_ok;

  generate
    for (genvar gi = 0; gi < ENGINE_NUM; gi++) begin : g_eng
      logic [3:0] cnt_q;
      logic       inc;
      logic       dec;

      assign addr_arr[gi]  = eng_araddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign len_arr[gi]   = eng_arlen[gi*8 +: 8];
      assign eligible[gi]  = eng_arvalid[gi] && (cnt_q < 4'(MAX_OUTSTANDING));
      // Count at grant capture so a burst parked in the slot already uses a credit.
      assign inc           = grant && (winner == ENG_BITS'(gi));
      assign dec           = r_done && (rid_idx == ENG_BITS'(gi));
      assign underflow[gi] = dec && !inc && (cnt_q == '0);
      assign outstanding[gi*4 +: 4] = cnt_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q <= '0;
        end else if (inc && !dec) begin
          cnt_q <= cnt_q + 4'd1;
        end else if (dec && !inc && (cnt_q != '0)) begin
          cnt_q <= cnt_q - 4'd1;
        end
      end

`ifdef MP_AR_ARB_GRANT_CNT_EN
      logic [31:0] gcnt_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          gcnt_q <= '0;
        end else if (inc && (gcnt_q != '1)) begin
          gcnt_q <= gcnt_q + 32'd1;
        end
      end
      assign grant_cnt[gi*32 +: 32] = gcnt_q;
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      m_arvalid_q <= 1'b0;
      m_arid_q    <= '0;
      m_araddr_q  <= '0;
      m_arlen_q   <= '0;
      ptr_q       <= '0;
      rid_err_q   <= 1'b0;
    end else begin
      rid_err_q <= rid_err_q || (m_rvalid && !rid_ok) || (|underflow);
      if (grant) begin
        state_q     <= HOLD;
        m_arvalid_q <= 1'b1;
        m_arid_q    <= ID_WIDTH'(winner);
        m_araddr_q  <= addr_arr[winner];
        m_arlen_q   <= len_arr[winner];
        ptr_q       <= winner + 1'b1;
      end else if (m_arready) begin
        state_q     <= IDLE;
        m_arvalid_q <= 1'b0;
      end
    end
  end

  assign m_arvalid = m_arvalid_q;
  assign m_arid    = m_arid_q;
  assign m_araddr  = m_araddr_q;
  assign m_arlen   = m_arlen_q;
  assign rid_err   = rid_err_q;

endmodule

// File: tb/tb_mp_ar_arbiter.sv
// Self-checking bench for mp_ar_arbiter: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level model of grants, credits and R routing.
module tb_mp_ar_arbiter;

  localparam int N    = 8;
  localparam int IDW  = 5;
  localparam int AW   = 64;
  localparam int MAXO = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    eng_arvalid = '0;
  logic [N*AW-1:0] eng_araddr = '0;
  logic [N*8-1:0]  eng_arlen = '0;
  logic [N-1:0]    eng_arready;
  logic [IDW-1:0]  m_arid;
  logic [AW-1:0]   m_araddr;
  logic [7:0]      m_arlen;
  logic            m_arvalid;
  logic            m_arready = 1'b0;
  logic [IDW-1:0]  m_rid = '0;
  logic            m_rlast = 1'b0;
  logic            m_rvalid = 1'b0;
  logic            m_rready;
  logic [N-1:0]    eng_rvalid;
  logic [N-1:0]    eng_rready = '0;
  logic [N*4-1:0]  outstanding;
  logic            rid_err;
`ifdef MP_AR_ARB_GRANT_CNT_EN
  logic [N*32-1:0] grant_cnt;
`endif

  mp_ar_arbiter #(
    .ENGINE_NUM(N), .ENG_BITS(3), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset(reset),
    .eng_arvalid(eng_arvalid), .eng_araddr(eng_araddr), .eng_arlen(eng_arlen),
    .eng_arready(eng_arready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .eng_rvalid(eng_rvalid), .eng_rready(eng_rready),
    .outstanding(outstanding), .rid_err(rid_err)
`ifdef MP_AR_ARB_GRANT_CNT_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: credit counts, bursts accepted by host, slot contents, rotation pointer.
  int          mdl_cnt    [N];
  int          mdl_issued [N];
  int          mdl_ptr;
  bit          mdl_valid;
  int          mdl_id;
  logic [63:0] mdl_addr;
  logic [7:0]  mdl_len;
  bit          mdl_err;
  bit          mdl_rst_state;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < N; i++) begin
      mdl_cnt[i]    = 0;
      mdl_issued[i] = 0;
    end
    mdl_ptr       = 0;
    mdl_valid     = 0;
    mdl_id        = 0;
    mdl_addr      = '0;
    mdl_len       = '0;
    mdl_err       = 0;
    mdl_rst_state = 1;
  endtask

  task automatic step(input logic [N-1:0] av, input logic ar_rdy, input logic rv,
                      input logic [IDW-1:0] rid, input logic rl, input logic [N-1:0] rr,
                      input logic rst);
    int          win;
    int          rid_int;
    bit          rid_ok;
    bit          done;
    logic [N-1:0]   exp_ardy;
    logic [N-1:0]   exp_rv;
    logic           exp_rrdy;
    logic [N*4-1:0] exp_out;
    @(negedge clk);
    reset       = rst;
    eng_arvalid = av;
    m_arready   = ar_rdy;
    m_rvalid    = rv;
    m_rid       = rid;
    m_rlast     = rl;
    eng_rready  = rr;
    for (int i = 0; i < N; i++) begin
      eng_araddr[i*AW +: AW] = {$urandom, $urandom};
      eng_arlen[i*8 +: 8]    = 8'($urandom);
    end

    // Rotating scan for the first requester with a free credit.
    win = -1;
    if (!rst && (!mdl_valid || ar_rdy)) begin
      for (int k = 0; k < N; k++) begin
        int e;
        e = (mdl_ptr + k) % N;
        if (win < 0 && av[e] && mdl_cnt[e] < MAXO) win = e;
      end
    end
    exp_ardy = '0;
    if (win >= 0) exp_ardy[win] = 1'b1;

    rid_int  = int'(rid);
    rid_ok   = (rid_int < N);
    exp_rv   = '0;
    exp_rrdy = 1'b1;
    if (rid_ok) begin
      exp_rv[rid_int] = rv;
      exp_rrdy        = rr[rid_int];
    end
    for (int i = 0; i < N; i++) exp_out[i*4 +: 4] = 4'(mdl_cnt[i]);

    #1;
    chk("eng_arready", 64'(eng_arready), 64'(exp_ardy));
    chk("eng_rvalid",  64'(eng_rvalid),  64'(exp_rv));
    chk("m_rready",    64'(m_rready),    64'(exp_rrdy));
    chk("m_arvalid",   64'(m_arvalid),   64'(mdl_valid));
    chk("outstanding", 64'(outstanding), 64'(exp_out));
    chk("rid_err",     64'(rid_err),     64'(mdl_err));
    if (mdl_valid || mdl_rst_state) begin
      chk("m_arid",   64'(m_arid),   64'(mdl_id));
      chk("m_araddr", m_araddr,      mdl_addr);
      chk("m_arlen",  64'(m_arlen),  64'(mdl_len));
    end

    @(posedge clk);
    if (rst) begin
      mdl_reset();
    end else begin
      if (mdl_valid && ar_rdy) begin
        mdl_issued[mdl_id]++;
        mdl_valid = 0;
      end
      if (win >= 0) begin
        mdl_valid     = 1;
        mdl_id        = win;
        mdl_addr      = eng_araddr[win*AW +: AW];
        mdl_len       = eng_arlen[win*8 +: 8];
        mdl_ptr       = (win + 1) % N;
        mdl_cnt[win]++;
        mdl_rst_state = 0;
      end
      if (rv && !rid_ok) mdl_err = 1;
      done = rv && exp_rrdy && rl && rid_ok;
      if (done) begin
        if (win == rid_int)             mdl_cnt[rid_int]--;
        else if (mdl_cnt[rid_int] == 0) mdl_err = 1;
        else                            mdl_cnt[rid_int]--;
        if (mdl_issued[rid_int] > 0) mdl_issued[rid_int]--;
      end
    end
  endtask

  task automatic idle(input logic [N-1:0] av, input logic ar_rdy, input int n);
    for (int c = 0; c < n; c++) step(av, ar_rdy, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    step('0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    step('0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    mdl_reset();
    do_reset();
    idle('0, 1'b0, 1);

    // Engines 0, 3, 5 streaming into an always-ready host.
    idle(8'b0010_1001, 1'b1, 7);
    do_reset();

    // Engine 2 alone exhausts its credits, then one returned burst frees one.
    idle(8'b0000_0100, 1'b1, 6);
    step(8'b0000_0100, 1'b1, 1'b1, 5'd2, 1'b1, 8'b0000_0100, 1'b0);
    idle(8'b0000_0100, 1'b1, 3);
    do_reset();

    // Engine 1 held in the slot while the host back-pressures.
    idle(8'b0000_0010, 1'b0, 1);
    idle(8'hFF, 1'b0, 5);
    idle(8'h00, 1'b1, 2);
    do_reset();

    // Grant and last-beat return for engine 4 in the same cycle.
    idle(8'b0001_0000, 1'b1, 2);
    step(8'b0001_0000, 1'b1, 1'b1, 5'd4, 1'b1, 8'b0001_0000, 1'b0);
    idle(8'h00, 1'b1, 2);
    do_reset();

    // Return for an engine with nothing in flight.
    step('0, 1'b1, 1'b1, 5'd6, 1'b1, 8'hFF, 1'b0);
    idle('0, 1'b1, 2);
    do_reset();

    // Out-of-range RID is drained and flagged, and the flag sticks until reset.
    idle(8'h0F, 1'b1, 2);
    step(8'h0F, 1'b1, 1'b1, 5'b01001, 1'b1, 8'h00, 1'b0);
    idle(8'h0F, 1'b1, 3);
    step(8'hFF, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    idle(8'h00, 1'b0, 2);

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      logic [N-1:0]   av;
      logic           ar_rdy;
      logic           rv;
      logic [IDW-1:0] rid;
      logic           rl;
      logic [N-1:0]   rr;
      logic           rst;
      int             e;
      av     = N'($urandom);
      ar_rdy = ($urandom_range(0, 9) < 7);
      rr     = N'($urandom);
      rl     = $urandom_range(0, 1) == 1;
      rv     = 1'b0;
      rid    = '0;
      e      = $urandom_range(0, N - 1);
      if ($urandom_range(0, 99) < 2) begin
        rv  = 1'b1;
        rid = IDW'($urandom_range(N, 31));
      end else if (mdl_issued[e] > 0 && $urandom_range(0, 9) < 6) begin
        rv  = 1'b1;
        rid = IDW'(e);
      end
      rst = ($urandom_range(0, 199) == 0);
      step(av, ar_rdy, rv, rid, rl, rr, rst);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
